// File: rtl/cla_pkg.sv
// Shared types and constants for the byte-serial CLA add/subtract sequencer.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NBYTES_DEF = 4;
  localparam int ID_W       = 1;

  // Width of the byte index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add8.sv
// 8-bit carry-lookahead adder slice built from two 4-bit lookahead groups.
module add8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CIN,
  output logic [7:0] OUT,
  output logic       COUT
);

  // Returns carries c[4:1] of a 4-bit group, flattened two-level lookahead.
  function automatic logic [3:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & ci);
    return c;
  endfunction

  logic [7:0] w_p;
  logic [7:0] w_g;
  logic [3:0] w_c_lo;
  logic [3:0] w_c_hi;
  logic [7:0] w_cin_bits;

  assign w_p = A ^ B;
  assign w_g = A & B;

  // Lookahead carries for the low group, then the high group chained on c4.
  always_comb begin
    w_c_lo     = cla4(w_p[3:0], w_g[3:0], CIN);
    w_c_hi     = cla4(w_p[7:4], w_g[7:4], w_c_lo[3]);
    w_cin_bits = {w_c_hi[2:0], w_c_lo[3:0], CIN};
  end

  assign OUT  = w_p ^ w_cin_bits;
  assign COUT = w_c_hi[3];

endmodule

// File: rtl/cla_seq_arb.sv
// Byte-serial NBYTES x 8 add/subtract sequencer sharing one add8 slice
// between two round-robin arbitrated requesters.
module cla_seq_arb
  import cla_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*NBYTES-1:0]   req0_a,
  input  logic [8*NBYTES-1:0]   req0_b,
  input  logic                  req0_sub,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*NBYTES-1:0]   req1_a,
  input  logic [8*NBYTES-1:0]   req1_b,
  input  logic                  req1_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = idx_width(NBYTES);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic            r_ptr;
  logic [ID_W-1:0] r_id;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;

  logic            w_grant_any;
  logic            w_grant_id;
  logic            w_sel_sub;
  logic [7:0]      w_add_a;
  logic [7:0]      w_add_b;
  logic [7:0]      w_add_out;
  logic            w_add_cout;

  // Byte mux into the shared slice; byte k of the captured operands.
  assign w_add_a = r_a[8*r_k +: 8];
  assign w_add_b = r_b[8*r_k +: 8];

  add8 u_add8 (
    .A    (w_add_a),
    .B    (w_add_b),
    .CIN  (r_carry),
    .OUT  (w_add_out),
    .COUT (w_add_cout)
  );

  // Next-state, round-robin grant and ready generation.
  always_comb begin
    // NOTE: every output of this block is assigned a default first so no path leaves it holding a value (no latch).
    w_state_nxt = r_state;
    w_grant_any = 1'b0;
    w_grant_id  = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          w_grant_any = 1'b1;
          // On a tie the requester not granted last wins.
          w_grant_id  = (req0_valid && req1_valid) ? ~r_ptr : req1_valid;
          req0_ready  = ~w_grant_id;
          req1_ready  = w_grant_id;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_k == KW'(NBYTES - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sel_sub = w_grant_id ? req1_sub : req0_sub;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture on grant, then one sum byte and carry per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_carry <= 1'b0;
      r_ptr   <= 1'b1;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_ptr   <= w_grant_id;
            r_id    <= ID_W'(w_grant_id);
            r_a     <= w_grant_id ? req1_a : req0_a;
            // Subtract is a + ~b + 1: invert b here, seed the carry with 1.
            r_b     <= (w_grant_id ? req1_b : req0_b) ^ {W{w_sel_sub}};
            r_carry <= w_sel_sub;
            r_k     <= '0;
          end
        end
        RUN: begin
          r_sum[8*r_k +: 8] <= w_add_out;
          r_carry           <= w_add_cout;
          r_k               <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_carry;
  assign rsp_ovf   = (r_a[W-1] == r_b[W-1]) && (r_sum[W-1] != r_a[W-1]);

endmodule
